// File: rtl/i2c_slave_regs.sv
// I2C target exposing a 4-entry byte register bank at addresses SLAVE_BASE:xx.
// SCL/SDA are oversampled on clk; SDA is open-drain (driven low or released).
module i2c_slave_regs #(
    parameter logic [4:0]  SLAVE_BASE  = 5'b10100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] status_in,
    input  logic [1:0] host_sel,
    output logic [7:0] host_rdata,
    output logic       wr_pulse,
    output logic [1:0] wr_sel,
    output logic [7:0] wr_data,
    output logic       addressed
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StWaitStop
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES:0]   sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;

    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            rw_q, rw_d;
    logic            sda_oe_q, sda_oe_d;
    logic            addressed_q, addressed_d;
    logic            wr_pulse_q, wr_pulse_d;
    logic [1:0]      wr_sel_q, wr_sel_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic [2:0][7:0] regs_q, regs_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall;
    logic       start_det, stop_det;
    logic [7:0] rx_byte;
    logic [7:0] ptr_byte;

    // SDA gets one extra stage so a data change at SCL fall never looks like START/STOP.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-1:0], sda};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES];
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        scl_rise   = scl_s & ~scl_prev_q;
        scl_fall   = ~scl_s & scl_prev_q;
        start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
        rx_byte    = {shift_q[6:0], sda_s};
    end

    // State register and datapath flops.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= StIdle;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            bit_cnt_q   <= 3'd7;
            shift_q     <= 8'h00;
            ptr_q       <= 2'd0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            addressed_q <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_sel_q    <= 2'd0;
            wr_data_q   <= 8'h00;
            regs_q      <= '0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            addressed_q <= addressed_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_sel_q    <= wr_sel_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        addressed_d = addressed_q;
        wr_pulse_d  = 1'b0;
        wr_sel_d    = wr_sel_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 3'd7;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d     = StIdle;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end

                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            bit_cnt_d = 3'd7;
                            if (rx_byte[7:3] == SLAVE_BASE) begin
                                ptr_d       = rx_byte[2:1];
                                rw_d        = rx_byte[0];
                                addressed_d = 1'b1;
                                state_d     = StAddrAck;
                            end else begin
                                addressed_d = 1'b0;
                                state_d     = StWaitStop;
                            end
                        end
                    end
                end

                // sda_oe_q doubles as the ACK phase: first fall drives, second releases.
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q) begin
                            shift_d   = ptr_byte;
                            ptr_d     = ptr_q + 2'd1;
                            bit_cnt_d = 3'd7;
                            sda_oe_d  = ~ptr_byte[7];
                            state_d   = StRdData;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd7;
                            state_d   = StWrData;
                        end
                    end
                end

                StWrData: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            unique case (ptr_q)
                                2'd0:    regs_d[0] = rx_byte;
                                2'd1:    regs_d[1] = rx_byte;
                                2'd2:    regs_d[2] = rx_byte;
                                default: ;
                            endcase
                            wr_pulse_d = 1'b1;
                            wr_sel_d   = ptr_q;
                            wr_data_d  = rx_byte;
                            ptr_d      = ptr_q + 2'd1;
                            bit_cnt_d  = 3'd7;
                            state_d    = StWrAck;
                        end
                    end
                end

                StWrAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd7;
                            state_d   = StWrData;
                        end
                    end
                end

                // Rotate so the next bit to present always sits in shift_q[7].
                StRdData: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = StRdAck;
                        end else begin
                            shift_d   = {shift_q[6:0], shift_q[7]};
                            bit_cnt_d = bit_cnt_q - 3'd1;
                            sda_oe_d  = ~shift_q[6];
                        end
                    end
                end

                StRdAck: begin
                    if (scl_rise && sda_s) begin
                        state_d = StWaitStop;
                    end else if (scl_fall) begin
                        shift_d   = ptr_byte;
                        ptr_d     = ptr_q + 2'd1;
                        bit_cnt_d = 3'd7;
                        sda_oe_d  = ~ptr_byte[7];
                        state_d   = StRdData;
                    end
                end

                StWaitStop: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs and register read muxes.
    always_comb begin
        unique case (host_sel)
            2'd0:    host_rdata = regs_q[0];
            2'd1:    host_rdata = regs_q[1];
            2'd2:    host_rdata = regs_q[2];
            default: host_rdata = status_in;
        endcase

        unique case (ptr_q)
            2'd0:    ptr_byte = regs_q[0];
            2'd1:    ptr_byte = regs_q[1];
            2'd2:    ptr_byte = regs_q[2];
            default: ptr_byte = status_in;
        endcase

        wr_pulse  = wr_pulse_q;
        wr_sel    = wr_sel_q;
        wr_data   = wr_data_q;
        addressed = addressed_q;
    end

    assign sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged bus master plus pulse/drive monitors.
module tb_i2c_slave_regs;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       arst;
    logic       scl;
    logic       sda_low;
    wire        sda;
    logic [7:0] status_in;
    logic [1:0] host_sel;
    logic [7:0] host_rdata;
    logic       wr_pulse;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic       addressed;

    int         n_checks = 0;
    int         n_fails = 0;
    int         pulse_cnt = 0;
    int         slave_low_cnt = 0;
    logic [1:0] last_sel = 2'd0;
    logic [7:0] last_data = 8'h00;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_regs dut (
        .clk        (clk),
        .arst       (arst),
        .scl        (scl),
        .sda        (sda),
        .status_in  (status_in),
        .host_sel   (host_sel),
        .host_rdata (host_rdata),
        .wr_pulse   (wr_pulse),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .addressed  (addressed)
    );

    always @(negedge clk) begin
        #2;
        if (wr_pulse === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            last_sel  = wr_sel;
            last_data = wr_data;
        end
        if (sda === 1'b0 && !sda_low) slave_low_cnt = slave_low_cnt + 1;
    end

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic rd);
        sda_low = ~b;
        qwait();
        scl = 1'b1;
        qwait();
        rd = sda;
        qwait();
        scl = 1'b0;
        qwait();
    endtask

    task automatic i2c_start();
        sda_low = 1'b0;
        qwait();
        scl = 1'b1;
        qwait();
        sda_low = 1'b1;
        qwait();
        scl = 1'b0;
        qwait();
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        qwait();
        scl = 1'b1;
        qwait();
        sda_low = 1'b0;
        qwait();
        qwait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, d);
            b[i] = d;
        end
        bit_xfer(nack, d);
    endtask

    task automatic test_reset();
        arst = 1'b1; scl = 1'b1; sda_low = 1'b0; host_sel = 2'd0; status_in = 8'h81;
        repeat (3) @(negedge clk);
        n_checks++; if (wr_pulse !== 1'b0) begin n_fails++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
        n_checks++; if (wr_sel !== 2'd0) begin n_fails++; $display("FAIL reset_wr_sel: got %h want 0", wr_sel); end
        n_checks++; if (wr_data !== 8'h00) begin n_fails++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
        n_checks++; if (addressed !== 1'b0) begin n_fails++; $display("FAIL reset_addressed: got %b want 0", addressed); end
        n_checks++; if (sda !== 1'b1) begin n_fails++; $display("FAIL reset_sda: got %b want 1", sda); end
        for (int s = 0; s < 3; s++) begin
            host_sel = 2'(s); #1;
            n_checks++; if (host_rdata !== 8'h00) begin n_fails++; $display("FAIL reset_reg%0d: got %h want 00", s, host_rdata); end
        end
        host_sel = 2'd3; #1;
        n_checks++; if (host_rdata !== 8'h81) begin n_fails++; $display("FAIL reset_status: got %h want 81", host_rdata); end
        @(negedge clk);
        arst = 1'b0;
        qwait();
    endtask

    task automatic test_write();
        logic ack;
        int   pc0;
        pc0 = pulse_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
        n_checks++; if (addressed !== 1'b1) begin n_fails++; $display("FAIL wr_addressed: got %b want 1", addressed); end
        write_byte(8'hA5, ack);
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL wr_data_ack: got %b want 0", ack); end
        i2c_stop();
        n_checks++; if (pulse_cnt - pc0 !== 1) begin n_fails++; $display("FAIL wr_pulse_count: got %0d want 1", pulse_cnt - pc0); end
        n_checks++; if (last_sel !== 2'd1) begin n_fails++; $display("FAIL wr_sel: got %h want 1", last_sel); end
        n_checks++; if (last_data !== 8'hA5) begin n_fails++; $display("FAIL wr_data: got %h want a5", last_data); end
        host_sel = 2'd1; #1;
        n_checks++; if (host_rdata !== 8'hA5) begin n_fails++; $display("FAIL wr_readback: got %h want a5", host_rdata); end
        n_checks++; if (addressed !== 1'b0) begin n_fails++; $display("FAIL wr_addressed_stop: got %b want 0", addressed); end
    endtask

    task automatic test_no_match();
        logic ack;
        int   pc0, sl0;
        pc0 = pulse_cnt;
        sl0 = slave_low_cnt;
        i2c_start();
        write_byte(8'h60, ack);
        n_checks++; if (ack !== 1'b1) begin n_fails++; $display("FAIL nm_addr_ack: got %b want 1", ack); end
        n_checks++; if (addressed !== 1'b0) begin n_fails++; $display("FAIL nm_addressed: got %b want 0", addressed); end
        write_byte(8'h12, ack);
        n_checks++; if (ack !== 1'b1) begin n_fails++; $display("FAIL nm_data_ack: got %b want 1", ack); end
        n_checks++; if (slave_low_cnt !== sl0) begin n_fails++; $display("FAIL nm_sda_driven: got %0d low samples want 0", slave_low_cnt - sl0); end
        n_checks++; if (pulse_cnt !== pc0) begin n_fails++; $display("FAIL nm_pulse: got %0d pulses want 0", pulse_cnt - pc0); end
        i2c_start();
        write_byte(8'hA0, ack);
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL nm_restart_ack: got %b want 0", ack); end
        n_checks++; if (addressed !== 1'b1) begin n_fails++; $display("FAIL nm_restart_addressed: got %b want 1", addressed); end
        i2c_stop();
    endtask

    task automatic test_read_nack();
        logic       ack, d;
        logic [7:0] b;
        int         sl0;
        i2c_start();
        write_byte(8'hA4, ack);
        write_byte(8'h3C, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'hA5, ack);
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
        read_byte(1'b1, b);
        n_checks++; if (b !== 8'h3C) begin n_fails++; $display("FAIL rd_byte: got %h want 3c", b); end
        n_checks++; if (addressed !== 1'b1) begin n_fails++; $display("FAIL rd_addressed_wait: got %b want 1", addressed); end
        sl0 = slave_low_cnt;
        bit_xfer(1'b1, d);
        n_checks++; if (d !== 1'b1 || slave_low_cnt !== sl0) begin
            n_fails++; $display("FAIL rd_wait_stop_release: got sda %b low samples %0d want 1/0", d, slave_low_cnt - sl0);
        end
        i2c_stop();
        n_checks++; if (addressed !== 1'b0) begin n_fails++; $display("FAIL rd_addressed_stop: got %b want 0", addressed); end
    endtask

    task automatic test_read_wrap();
        logic       ack;
        logic [7:0] b;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h5A, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'hA7, ack);
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL wrap_addr_ack: got %b want 0", ack); end
        read_byte(1'b0, b);
        n_checks++; if (b !== 8'h81) begin n_fails++; $display("FAIL wrap_status: got %h want 81", b); end
        read_byte(1'b1, b);
        n_checks++; if (b !== 8'h5A) begin n_fails++; $display("FAIL wrap_reg0: got %h want 5a", b); end
        i2c_stop();
    endtask

    task automatic test_write_ro();
        logic       ack;
        logic [7:0] exp_regs [4];
        int         pc0;
        exp_regs[0] = 8'h5A; exp_regs[1] = 8'hA5; exp_regs[2] = 8'h3C; exp_regs[3] = 8'h81;
        pc0 = pulse_cnt;
        i2c_start();
        write_byte(8'hA6, ack);
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL ro_addr_ack: got %b want 0", ack); end
        write_byte(8'hFF, ack);
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL ro_data_ack: got %b want 0", ack); end
        i2c_stop();
        n_checks++; if (pulse_cnt - pc0 !== 1 || last_sel !== 2'd3 || last_data !== 8'hFF) begin
            n_fails++; $display("FAIL ro_pulse: got %0d/%h/%h want 1/3/ff", pulse_cnt - pc0, last_sel, last_data);
        end
        for (int s = 0; s < 4; s++) begin
            host_sel = 2'(s); #1;
            n_checks++; if (host_rdata !== exp_regs[s]) begin
                n_fails++; $display("FAIL ro_bank%0d: got %h want %h", s, host_rdata, exp_regs[s]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic ack, d;
        int   pc0;
        i2c_start();
        write_byte(8'hA3, ack);
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL rst_addr_ack: got %b want 0", ack); end
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, d);
        sda_low = 1'b0;
        qwait();
        scl = 1'b1;
        qwait();
        n_checks++; if (sda !== 1'b0) begin n_fails++; $display("FAIL rst_bit4_driven: got %b want 0", sda); end
        #3 arst = 1'b1;
        #1;
        n_checks++; if (sda !== 1'b1) begin n_fails++; $display("FAIL rst_sda_release: got %b want 1", sda); end
        n_checks++; if (wr_sel !== 2'd0 || wr_data !== 8'h00 || wr_pulse !== 1'b0 || addressed !== 1'b0) begin
            n_fails++; $display("FAIL rst_outputs: got %h/%h/%b/%b want 0/00/0/0", wr_sel, wr_data, wr_pulse, addressed);
        end
        host_sel = 2'd1; #1;
        n_checks++; if (host_rdata !== 8'h00) begin n_fails++; $display("FAIL rst_reg1: got %h want 00", host_rdata); end
        repeat (3) @(negedge clk);
        arst = 1'b0;
        qwait();
        qwait();
        pc0 = pulse_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL post_rst_addr_ack: got %b want 0", ack); end
        write_byte(8'h11, ack);
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL post_rst_data_ack: got %b want 0", ack); end
        i2c_stop();
        n_checks++; if (pulse_cnt - pc0 !== 1 || last_sel !== 2'd0 || last_data !== 8'h11) begin
            n_fails++; $display("FAIL post_rst_pulse: got %0d/%h/%h want 1/0/11", pulse_cnt - pc0, last_sel, last_data);
        end
        host_sel = 2'd0; #1;
        n_checks++; if (host_rdata !== 8'h11) begin n_fails++; $display("FAIL post_rst_reg0: got %h want 11", host_rdata); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_no_match();
        test_read_nack();
        test_read_wrap();
        test_write_ro();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
